// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding control for the five-stage pipeline.
// Keeps the destination register, result latency and source registers of the
// instructions in E, M and W, and works out the stall signal and the bypass
// mux selects for the D, E and M stages.
module hazard_fwd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_a3,
  input  logic [1:0] d_tnew,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       fwd_m_rt
);

  // E stage record
  logic [4:0] e_a3;
  logic [1:0] e_tnew;
  logic [4:0] e_rs;
  logic [4:0] e_rt;

  // M stage record; its tnew is already one cycle closer to ready than in E
  logic [4:0] m_a3;
  logic [1:0] m_tnew;
  logic [4:0] m_rt;

  // W stage record; a W result is always ready
  logic [4:0] w_a3;

  logic       e_bubble;
  logic       stall_rs;
  logic       stall_rt;

  // A D operand has to wait if the nearest producer of it cannot deliver in
  // time. Only the nearest matching stage counts, and W never stalls.
  function automatic logic op_stall(input logic [4:0] r, input logic [1:0] tuse,
                                    input logic [4:0] ea3, input logic [1:0] etnew,
                                    input logic [4:0] ma3, input logic [1:0] mtnew);
    op_stall = 1'b0;
    if (tuse != 2'd3 && r != 5'd0) begin
      if (r == ea3)
        op_stall = (etnew > tuse);
      else if (r == ma3)
        op_stall = (mtnew > tuse);
    end
  endfunction

  // D bypass: nearest matching stage wins; a not-yet-ready nearest match
  // falls back to the register file and the stall keeps things correct.
  function automatic logic [1:0] d_sel(input logic [4:0] r,
                                       input logic [4:0] ea3, input logic [1:0] etnew,
                                       input logic [4:0] ma3, input logic [1:0] mtnew,
                                       input logic [4:0] wa3);
    d_sel = 2'b00;
    if (r != 5'd0) begin
      if (r == ea3)
        d_sel = (etnew == 2'd0) ? 2'b01 : 2'b00;
      else if (r == ma3)
        d_sel = (mtnew == 2'd0) ? 2'b10 : 2'b00;
      else if (r == wa3)
        d_sel = 2'b11;
    end
  endfunction

  // E bypass: M beats W, and M is only usable once its result exists.
  function automatic logic [1:0] e_sel(input logic [4:0] r,
                                       input logic [4:0] ma3, input logic [1:0] mtnew,
                                       input logic [4:0] wa3);
    e_sel = 2'b00;
    if (r != 5'd0) begin
      if (r == ma3)
        e_sel = (mtnew == 2'd0) ? 2'b01 : 2'b00;
      else if (r == wa3)
        e_sel = 2'b10;
    end
  endfunction

  // Stall and forwarding selects, purely from the records and the D inputs
  always_comb begin
    stall_rs = op_stall(d_rs, d_tuse_rs, e_a3, e_tnew, m_a3, m_tnew);
    stall_rt = op_stall(d_rt, d_tuse_rt, e_a3, e_tnew, m_a3, m_tnew);
    stall    = d_valid && (stall_rs || stall_rt);
    fwd_d_rs = d_sel(d_rs, e_a3, e_tnew, m_a3, m_tnew, w_a3);
    fwd_d_rt = d_sel(d_rt, e_a3, e_tnew, m_a3, m_tnew, w_a3);
    fwd_e_rs = e_sel(e_rs, m_a3, m_tnew, w_a3);
    fwd_e_rt = e_sel(e_rt, m_a3, m_tnew, w_a3);
    fwd_m_rt = (m_rt != 5'd0) && (m_rt == w_a3);
    e_bubble = stall || !d_valid;
  end

  // Shift the records down the pipe every cycle, inserting a bubble into E
  // when D is stalled or empty; tnew counts down and stops at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3   <= 5'd0;
      e_tnew <= 2'd0;
      e_rs   <= 5'd0;
      e_rt   <= 5'd0;
      m_a3   <= 5'd0;
      m_tnew <= 2'd0;
      m_rt   <= 5'd0;
      w_a3   <= 5'd0;
    end else begin
      w_a3   <= m_a3;
      m_a3   <= e_a3;
      m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
      m_rt   <= e_rt;
      if (e_bubble) begin
        e_a3   <= 5'd0;
        e_tnew <= 2'd0;
        e_rs   <= 5'd0;
        e_rt   <= 5'd0;
      end else begin
        e_a3   <= d_a3;
        e_tnew <= d_tnew;
        e_rs   <= d_rs;
        e_rt   <= d_rt;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed testbench for hazard_fwd_ctrl with hand-computed expectations.
module tb_hazard_fwd_ctrl;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_a3;
  logic [1:0] d_tnew;
  logic       stall;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;
  logic       fwd_m_rt;

  int errCount   = 0;
  int checkCount = 0;

  hazard_fwd_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .d_valid  (d_valid),
    .d_rs     (d_rs),
    .d_rt     (d_rt),
    .d_tuse_rs(d_tuse_rs),
    .d_tuse_rt(d_tuse_rt),
    .d_a3     (d_a3),
    .d_tnew   (d_tnew),
    .stall    (stall),
    .fwd_d_rs (fwd_d_rs),
    .fwd_d_rt (fwd_d_rt),
    .fwd_e_rs (fwd_e_rs),
    .fwd_e_rt (fwd_e_rt),
    .fwd_m_rt (fwd_m_rt)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one D-stage instruction and let the combinational outputs settle
  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] trs, input logic [1:0] trt,
                               input logic [4:0] a3, input logic [1:0] tnew);
    d_valid   = v;
    d_rs      = rs;
    d_rt      = rt;
    d_tuse_rs = trs;
    d_tuse_rt = trt;
    d_a3      = a3;
    d_tnew    = tnew;
    #1;
  endtask

  // Empty D slot
  task automatic applyBubble();
    applyStimulus(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
  endtask

  // Advance one clock edge, then move a little past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drain the pipe so the next scenario starts from empty records
  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      applyBubble();
      step();
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] actual, input logic [1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
    step();
    reset = 1'b0;

    // reset: empty records, D still asks for $5 in D
    applyStimulus(1'b1, 5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
    checkOutput("rst_stall", {1'b0, stall}, 2'b00);
    checkOutput("rst_fdrs", fwd_d_rs, 2'b00);
    checkOutput("rst_fdrt", fwd_d_rt, 2'b00);
    checkOutput("rst_fers", fwd_e_rs, 2'b00);
    checkOutput("rst_fert", fwd_e_rt, 2'b00);
    checkOutput("rst_fmrt", {1'b0, fwd_m_rt}, 2'b00);
    flush();

    // ALU result feeding a branch: one stall, then M bypass
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1);
    step();
    applyStimulus(1'b1, 5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
    checkOutput("alu_br_stall1", {1'b0, stall}, 2'b01);
    checkOutput("alu_br_fdrs1", fwd_d_rs, 2'b00);
    step();
    applyStimulus(1'b1, 5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
    checkOutput("alu_br_stall2", {1'b0, stall}, 2'b00);
    checkOutput("alu_br_fdrs2", fwd_d_rs, 2'b10);
    step();
    flush();

    // Load-use with Tuse=1: one stall, then W bypass into E
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd2);
    step();
    applyStimulus(1'b1, 5'd9, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1);
    checkOutput("lu_stall1", {1'b0, stall}, 2'b01);
    step();
    applyStimulus(1'b1, 5'd9, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1);
    checkOutput("lu_stall2", {1'b0, stall}, 2'b00);
    checkOutput("lu_fdrs2", fwd_d_rs, 2'b00);
    step();
    applyBubble();
    checkOutput("lu_fers3", fwd_e_rs, 2'b10);
    flush();

    // Load feeding a D consumer on rt: two stalls, then W bypass
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2);
    step();
    applyStimulus(1'b1, 5'd0, 5'd7, 2'd3, 2'd0, 5'd0, 2'd0);
    checkOutput("ld_br_stall1", {1'b0, stall}, 2'b01);
    step();
    applyStimulus(1'b1, 5'd0, 5'd7, 2'd3, 2'd0, 5'd0, 2'd0);
    checkOutput("ld_br_stall2", {1'b0, stall}, 2'b01);
    step();
    applyStimulus(1'b1, 5'd0, 5'd7, 2'd3, 2'd0, 5'd0, 2'd0);
    checkOutput("ld_br_stall3", {1'b0, stall}, 2'b00);
    checkOutput("ld_br_fdrt3", fwd_d_rt, 2'b11);
    step();
    flush();

    // $0 never matches
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2);
    step();
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    checkOutput("zero_stall", {1'b0, stall}, 2'b00);
    checkOutput("zero_fdrs", fwd_d_rs, 2'b00);
    step();
    flush();

    // jal-class producer in E, consumer with rs == rt: both select E
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd0);
    step();
    applyStimulus(1'b1, 5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 2'd0);
    checkOutput("same_stall", {1'b0, stall}, 2'b00);
    checkOutput("same_fdrs", fwd_d_rs, 2'b01);
    checkOutput("same_fdrt", fwd_d_rt, 2'b01);
    step();
    flush();

    // tnew=0 stays 0 when moving to M (no wrap to 3)
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd0);
    step();
    applyBubble();
    step();
    applyStimulus(1'b1, 5'd3, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0);
    checkOutput("sat_stall", {1'b0, stall}, 2'b00);
    checkOutput("sat_fdrs", fwd_d_rs, 2'b10);
    step();
    flush();

    // two writers to $4 back to back: nearest one wins in E
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1);
    step();
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1);
    step();
    applyStimulus(1'b1, 5'd4, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0);
    checkOutput("prio_stall", {1'b0, stall}, 2'b00);
    checkOutput("prio_fdrs", fwd_d_rs, 2'b00);
    step();
    applyBubble();
    checkOutput("prio_fers", fwd_e_rs, 2'b01);
    flush();

    // store data: writer of $4 ahead of sw with rt=4
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1);
    step();
    applyStimulus(1'b1, 5'd0, 5'd4, 2'd3, 2'd2, 5'd0, 2'd0);
    checkOutput("sw_stall", {1'b0, stall}, 2'b00);
    step();
    applyBubble();
    checkOutput("sw_fert", fwd_e_rt, 2'b01);
    checkOutput("sw_fmrt_early", {1'b0, fwd_m_rt}, 2'b00);
    step();
    applyBubble();
    checkOutput("sw_fmrt", {1'b0, fwd_m_rt}, 2'b01);
    flush();

    // reset in the middle of a load-use stall discards the load
    applyStimulus(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd2);
    step();
    applyStimulus(1'b1, 5'd9, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1);
    checkOutput("rstmid_stall1", {1'b0, stall}, 2'b01);
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulus(1'b1, 5'd9, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1);
    checkOutput("rstmid_stall2", {1'b0, stall}, 2'b00);
    checkOutput("rstmid_fers", fwd_e_rs, 2'b00);
    step();
    applyBubble();
    checkOutput("rstmid_fers_next", fwd_e_rs, 2'b00);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
